// File: rtl/mc_controller_if.sv
// Control bus between the multicycle MIPS datapath and its control unit.
// master = control unit, slave = datapath.
interface mc_controller_if #(parameter int STATE_W = 4);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
  logic               memwrite;
  logic               lord;
  logic               irwrite;
  logic               regdst;
  logic               memtoreg;
  logic               regwrite;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [2:0]         alucontrol;
  logic               pcen;
  logic [1:0]         pcsrc;
  logic               badinstr;
  logic [STATE_W-1:0] state;

  // No valid/ready: op/funct/zero are taken as valid every cycle and
  // every control output is valid every cycle.
  modport master (
    input  op, funct, zero,
    output memwrite, lord, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, alucontrol, pcen, pcsrc, badinstr, state
  );

  modport slave (
    output op, funct, zero,
    input  memwrite, lord, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, alucontrol, pcen, pcsrc, badinstr, state
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM, ALU decoder and PC-enable logic.
// op/funct are captured in DECODE so later states ignore the live inputs.
module mc_controller #(
  parameter int STATE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  mc_controller_if.master   bus
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_q, state_d;
  logic       badinstr_q;
  logic       bad_set;
  logic       sw_q;
  logic       bne_q;
  logic [2:0] alu_q;
  logic [2:0] dec_alu;
  logic       dec_ok;

  always_comb begin
    dec_alu = ALU_ADD;
    dec_ok  = 1'b1;
    case (bus.funct)
      6'b100000: dec_alu = ALU_ADD;
      6'b100010: dec_alu = ALU_SUB;
      6'b100100: dec_alu = ALU_AND;
      6'b100101: dec_alu = ALU_OR;
      6'b101010: dec_alu = ALU_SLT;
      default:   dec_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH;
      badinstr_q <= 1'b0;
      sw_q       <= 1'b0;
      bne_q      <= 1'b0;
      alu_q      <= ALU_ADD;
    end else begin
      state_q <= state_d;
      if (bad_set) badinstr_q <= 1'b1;
      if (state_q == DECODE) begin
        sw_q  <= (bus.op == OP_SW);
        bne_q <= (bus.op == OP_BNE);
        alu_q <= dec_alu;
      end
    end
  end

  always_comb begin
    state_d = FETCH;
    bad_set = 1'b0;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:   state_d = MEMADR;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_ADDI:        state_d = ADDIEXEC;
          OP_J:           state_d = JUMP;
          OP_R: begin
            if (dec_ok) state_d = EXECUTE;
            else        bad_set = 1'b1;
          end
          default:        bad_set = 1'b1;
        endcase
      end
      MEMADR:   state_d = sw_q ? MEMWR : MEMRD;
      MEMRD:    state_d = MEMWB;
      EXECUTE:  state_d = ALUWB;
      ADDIEXEC: state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase
  end

  logic       memwrite, lord, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic       pcwrite, branch, branchne, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  always_comb begin
    memwrite   = 1'b0;
    lord       = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = 3'b000;
    pcsrc      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branchne   = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        irwrite    = 1'b1;
        pcwrite    = 1'b1;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
      end
      MEMADR, ADDIEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      MEMRD: lord = 1'b1;
      MEMWR: begin
        lord     = 1'b1;
        memwrite = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = alu_q;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      ADDIWB: regwrite = 1'b1;
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = ~bne_q;
        branchne   = bne_q;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    pcen = pcwrite | (branch & bus.zero) | (branchne & ~bus.zero);
    // Reset holds state at FETCH, so FETCH's enables must be masked here.
    if (!reset) begin
      memwrite   = 1'b0;
      lord       = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      alucontrol = 3'b000;
      pcsrc      = 2'b00;
      pcen       = 1'b0;
    end
  end

  assign bus.memwrite   = memwrite;
  assign bus.lord       = lord;
  assign bus.irwrite    = irwrite;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.regwrite   = regwrite;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.alucontrol = alucontrol;
  assign bus.pcen       = pcen;
  assign bus.pcsrc      = pcsrc;
  assign bus.badinstr   = badinstr_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: instruction-level reference model
// expands each opcode into its expected per-cycle output vectors.
module tb_mc_controller;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mc_controller_if bus ();
  mc_controller dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];
  logic        bad_m = 1'b0;
  logic [2:0]  seen_exec_alu;
  logic        seen_branch_pcen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // reference model
  function automatic logic [2:0] ref_alu(input logic [5:0] f, output logic ok);
    ok = 1'b1;
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default: begin ok = 1'b0; return 3'b000; end
    endcase
  endfunction

  // Packed order: state, memwrite, lord, irwrite, regdst, memtoreg, regwrite,
  // alusrca, alusrcb, alucontrol, pcen, pcsrc, badinstr.
  function automatic logic [19:0] exp_vec(input int s, input logic z, input logic [2:0] alu,
                                          input logic isbne, input logic bad);
    logic mw, lord, irw, rdst, mtr, rw, asa, pcen;
    logic [1:0] asb, pcs;
    logic [2:0] ac;
    {mw, lord, irw, rdst, mtr, rw, asa, pcen} = '0;
    asb = 2'b00; pcs = 2'b00; ac = 3'b000;
    case (s)
      0:  begin asb = 2'b01; ac = 3'b010; irw = 1'b1; pcen = 1'b1; end
      1:  begin asb = 2'b11; ac = 3'b010; end
      2, 9: begin asa = 1'b1; asb = 2'b10; ac = 3'b010; end
      3:  lord = 1'b1;
      4:  begin mtr = 1'b1; rw = 1'b1; end
      5:  begin lord = 1'b1; mw = 1'b1; end
      6:  begin asa = 1'b1; ac = alu; end
      7:  begin rdst = 1'b1; rw = 1'b1; end
      8:  begin asa = 1'b1; ac = 3'b110; pcs = 2'b01; pcen = isbne ? ~z : z; end
      10: rw = 1'b1;
      11: begin pcs = 2'b10; pcen = 1'b1; end
      default: ;
    endcase
    return {4'(s), mw, lord, irw, rdst, mtr, rw, asa, asb, ac, pcen, pcs, bad};
  endfunction

  // scoreboard: one expected vector per cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [19:0] e;
      logic [19:0] a;
      e = exp_q.pop_front();
      a = {bus.state, bus.memwrite, bus.lord, bus.irwrite, bus.regdst, bus.memtoreg,
           bus.regwrite, bus.alusrca, bus.alusrcb, bus.alucontrol, bus.pcen, bus.pcsrc,
           bus.badinstr};
      chk("cycle", 32'(a), 32'(e));
      if (bus.state == 4'd6) seen_exec_alu = bus.alucontrol;
      if (bus.state == 4'd8) seen_branch_pcen = bus.pcen;
    end
  end

  // driver: entered and left at posedge+1 with the DUT in FETCH
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input int zmode,
                           input int abort_at);
    int seq[$];
    logic ok;
    logic [2:0] alu;
    alu = ref_alu(f, ok);
    seq = {0, 1};
    case (op)
      OP_LW:          seq = {0, 1, 2, 3, 4};
      OP_SW:          seq = {0, 1, 2, 5};
      OP_R:           if (ok) seq = {0, 1, 6, 7};
      OP_BEQ, OP_BNE: seq = {0, 1, 8};
      OP_ADDI:        seq = {0, 1, 9, 10};
      OP_J:           seq = {0, 1, 11};
      default: ;
    endcase
    seen_exec_alu    = 3'bxxx;
    seen_branch_pcen = 1'bx;
    for (int i = 0; i < seq.size(); i++) begin
      logic z;
      z = 1'($urandom_range(0, 1));
      if (seq[i] == 8 && zmode >= 0) z = zmode[0];
      bus.zero = z;
      if (i < 2) begin
        bus.op    = op;
        bus.funct = f;
      end else begin
        bus.op    = 6'($urandom);
        bus.funct = 6'($urandom);
      end
      exp_q.push_back(exp_vec(seq[i], z, alu, op == OP_BNE, bad_m));
      if (i == 1 && seq.size() == 2) bad_m = 1'b1;
      if (i == abort_at) begin
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_memwrite", 32'(bus.memwrite), 32'd0);
        chk("abort_state", 32'(bus.state), 32'd0);
        bad_m = 1'b0;
        repeat (2) begin
          @(posedge clk); #1;
          exp_q.push_back(20'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  logic [5:0] legal_f[5] = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101};
  logic [2:0] legal_a[5] = '{3'b111, 3'b010, 3'b110, 3'b000, 3'b001};
  logic [5:0] op_tab[7]  = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_ADDI, OP_J};

  initial begin
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0;
    @(posedge clk); #1;
    repeat (3) begin
      exp_q.push_back(20'd0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #2;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_irwrite", 32'(bus.irwrite), 32'd1);
    chk("rst_pcen", 32'(bus.pcen), 32'd1);
    chk("rst_alusrcb", 32'(bus.alusrcb), 32'd1);
    chk("rst_badinstr", 32'(bus.badinstr), 32'd0);

    run_instr(OP_LW, 6'($urandom), -1, -1);
    for (int k = 0; k < 5; k++) begin
      run_instr(OP_R, legal_f[k], -1, -1);
      chk("rtype_alucontrol", 32'(seen_exec_alu), 32'(legal_a[k]));
    end
    run_instr(OP_BEQ, 6'($urandom), 1, -1);
    chk("beq_taken_pcen", 32'(seen_branch_pcen), 32'd1);
    run_instr(OP_BEQ, 6'($urandom), 0, -1);
    chk("beq_not_taken_pcen", 32'(seen_branch_pcen), 32'd0);
    run_instr(OP_BNE, 6'($urandom), 1, -1);
    chk("bne_not_taken_pcen", 32'(seen_branch_pcen), 32'd0);
    run_instr(OP_BNE, 6'($urandom), 0, -1);
    chk("bne_taken_pcen", 32'(seen_branch_pcen), 32'd1);
    run_instr(OP_J, 6'($urandom), -1, -1);
    run_instr(OP_SW, 6'($urandom), -1, -1);
    run_instr(6'b111111, 6'($urandom), -1, -1);
    run_instr(OP_ADDI, 6'($urandom), -1, -1);
    chk("badinstr_sticky", 32'(bus.badinstr), 32'd1);
    run_instr(OP_R, 6'b111111, -1, -1);
    run_instr(OP_SW, 6'($urandom), -1, 3);
    chk("badinstr_cleared", 32'(bus.badinstr), 32'd0);

    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      logic [5:0] f;
      int idx;
      idx = $urandom_range(0, 7);
      op  = (idx == 7) ? 6'($urandom) : op_tab[idx];
      f   = ($urandom_range(0, 3) != 0) ? legal_f[$urandom_range(0, 4)] : 6'($urandom);
      run_instr(op, f, -1, ($urandom_range(0, 30) == 0 && op == OP_SW) ? 3 : -1);
    end

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
